// File: rtl/scale_buf_ctrl.sv
// Purpose: scale-factor SRAM controller; LOAD writes a DMA word stream, READ streams words back out.
// Latency: LOAD writes in the handshake cycle; READ presents its first word 2 cycles after rd_start.
// Backpressure: s_ready is high throughout LOAD; READ stalls via a 2-entry buffer, no word lost.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   cfg_len                        word count, clamped to DEPTH, latched on an accepted start
//   load_start, rd_start           start pulses (accepted only when idle, LOAD has priority)
//   s_valid/s_ready/s_data         DMA word stream in (LOAD)
//   m_valid/m_ready/m_data/m_last  scale word stream out (READ)
//   busy, load_done, rd_done       status / completion pulses
//   mem_cs/we/addr/wdata/rdata     single-port SRAM, read data 1 cycle after issue
module scale_buf_ctrl #(
  parameter int DW    = 16,
  parameter int AW    = 4,
  parameter int DEPTH = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW:0]   cfg_len,
  input  logic          load_start,
  input  logic          rd_start,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [DW-1:0] s_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_data,
  output logic          m_last,
  output logic          busy,
  output logic          load_done,
  output logic          rd_done,
  output logic          mem_cs,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_READ} state_t;

  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);
  localparam logic [AW:0] CNT_ONE = {{AW{1'b0}}, 1'b1};

  state_t        state_q, state_d;
  logic [AW:0]   len_q, len_d;
  logic [AW:0]   wcnt_q, wcnt_d;
  logic [AW:0]   rcnt_q, rcnt_d;
  // A read issued last cycle: its data sits on mem_rdata this cycle.
  logic          infl_q, infl_d;
  logic          infl_last_q, infl_last_d;
  logic [1:0]    occ_q, occ_d;
  logic          wptr_q, wptr_d;
  logic          rptr_q, rptr_d;
  logic          load_done_q, load_done_d;
  logic          rd_done_q, rd_done_d;
  logic [DW-1:0] buf_dat_q [2];
  logic          buf_last_q [2];

  logic [AW:0]   eff_len;
  logic          head_vld;
  logic [DW-1:0] head_dat;
  logic          head_last;
  logic          m_hs;
  logic          push_en;
  logic          pop_stored;

  assign eff_len = (cfg_len > DEPTH_L) ? DEPTH_L : cfg_len;

  // The buffer falls through: with nothing stored, the word arriving on
  // mem_rdata is presented directly, which gives the 2-cycle first-word
  // latency and a gap-free stream when the consumer never stalls.
  assign head_vld  = (occ_q != 2'd0) || infl_q;
  assign head_dat  = (occ_q != 2'd0) ? buf_dat_q[rptr_q]  : mem_rdata;
  assign head_last = (occ_q != 2'd0) ? buf_last_q[rptr_q] : infl_last_q;

  assign m_valid   = (state_q == ST_READ) && head_vld;
  assign m_data    = m_valid ? head_dat : '0;
  assign m_last    = m_valid && head_last;
  assign m_hs      = m_valid && m_ready;
  assign busy      = (state_q != ST_IDLE);
  assign load_done = load_done_q;
  assign rd_done   = rd_done_q;

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    wcnt_d      = wcnt_q;
    rcnt_d      = rcnt_q;
    infl_d      = 1'b0;
    infl_last_d = 1'b0;
    occ_d       = occ_q;
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    load_done_d = 1'b0;
    rd_done_d   = 1'b0;
    s_ready     = 1'b0;
    mem_cs      = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    push_en     = 1'b0;
    pop_stored  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (load_start) begin
          if (eff_len == '0) begin
            load_done_d = 1'b1;
          end else begin
            state_d = ST_LOAD;
            len_d   = eff_len;
            wcnt_d  = '0;
          end
        end else if (rd_start) begin
          if (eff_len == '0) begin
            rd_done_d = 1'b1;
          end else begin
            state_d = ST_READ;
            len_d   = eff_len;
            rcnt_d  = '0;
          end
        end
      end

      ST_LOAD: begin
        s_ready = 1'b1;
        if (s_valid) begin
          mem_cs    = 1'b1;
          mem_we    = 1'b1;
          mem_addr  = wcnt_q[AW-1:0];
          mem_wdata = s_data;
          wcnt_d    = wcnt_q + CNT_ONE;
          if (wcnt_q == len_q - CNT_ONE) begin
            state_d     = ST_IDLE;
            load_done_d = 1'b1;
          end
        end
      end

      ST_READ: begin
        // Never commit more reads than the buffer can hold if the
        // consumer stalls from now on.
        if ((rcnt_q < len_q) && (({1'b0, occ_q} + {2'b00, infl_q}) < 3'd2)) begin
          mem_cs      = 1'b1;
          mem_addr    = rcnt_q[AW-1:0];
          rcnt_d      = rcnt_q + CNT_ONE;
          infl_d      = 1'b1;
          infl_last_d = (rcnt_q == len_q - CNT_ONE);
        end

        // Arriving word is stored unless it was consumed straight through.
        push_en    = infl_q && !((occ_q == 2'd0) && m_ready);
        pop_stored = m_hs && (occ_q != 2'd0);
        occ_d      = occ_q + {1'b0, push_en} - {1'b0, pop_stored};
        wptr_d     = wptr_q ^ push_en;
        rptr_d     = rptr_q ^ pop_stored;

        if (m_hs && head_last) begin
          state_d   = ST_IDLE;
          rd_done_d = 1'b1;
          push_en   = 1'b0;
          occ_d     = 2'd0;
          wptr_d    = 1'b0;
          rptr_d    = 1'b0;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      len_q       <= '0;
      wcnt_q      <= '0;
      rcnt_q      <= '0;
      infl_q      <= 1'b0;
      infl_last_q <= 1'b0;
      occ_q       <= 2'd0;
      wptr_q      <= 1'b0;
      rptr_q      <= 1'b0;
      load_done_q <= 1'b0;
      rd_done_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      wcnt_q      <= wcnt_d;
      rcnt_q      <= rcnt_d;
      infl_q      <= infl_d;
      infl_last_q <= infl_last_d;
      occ_q       <= occ_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      load_done_q <= load_done_d;
      rd_done_q   <= rd_done_d;
    end
  end

  // Storage needs no reset: occupancy and pointers decide what is valid.
  always_ff @(posedge clk) begin
    if (push_en) begin
      buf_dat_q[wptr_q]  <= mem_rdata;
      buf_last_q[wptr_q] <= infl_last_q;
    end
  end

endmodule

// File: doc/scale_buf_ctrl.md
Name: scale_buf_ctrl

Overview:
- Controller for the per-channel scale-factor SRAM (spram_wrapper_scale, 16x16).
- LOAD mode: accepts a valid/ready word stream from the DMA read path and writes it into the SRAM.
- READ mode: reads the words back and presents them as a valid/ready stream to the quantization/scaling stage.
- Absorbs the SRAM's 1-cycle read latency with a 2-entry output buffer, so downstream back-pressure never loses data.

Parameters:
- DW, 16, scale word width (matches SRAM DW).
- AW, 4, SRAM address width.
- DEPTH, 16, SRAM word count; cfg_len is clamped to DEPTH.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- cfg_len  in  AW+1  words to load/read; sampled on the accepted start
- load_start  in  1  pulse: begin LOAD at address 0
- rd_start  in  1  pulse: begin READ at address 0
- s_valid  in  1  DMA word valid
- s_ready  out  1  ctrl accepts DMA word
- s_data  in  DW  DMA word
- m_valid  out  1  scale word valid to consumer
- m_ready  in  1  consumer accepts
- m_data  out  DW  scale word
- m_last  out  1  marks final word of READ
- busy  out  1  high in LOAD or READ
- load_done  out  1  1-cycle pulse, last word written
- rd_done  out  1  1-cycle pulse, last word accepted by consumer
- mem_cs  out  1  SRAM chip-select
- mem_we  out  1  SRAM write enable
- mem_addr  out  AW  SRAM address
- mem_wdata  out  DW  SRAM write data
- mem_rdata  in  DW  SRAM read data, valid 1 cycle after read issue

Behaviour:
- Reset values: all outputs 0. FSM goes to IDLE, counters clear, output buffer flushes. SRAM contents are untouched.
- Reset mid-operation: aborts immediately; no done pulse is generated.
- FSM states: IDLE, LOAD, READ.
- Start acceptance:
  - Starts are accepted only in IDLE.
  - load_start and rd_start in the same cycle: LOAD wins and rd_start is dropped.
  - Starts while busy are ignored.
- Effective length: len = min(cfg_len, DEPTH), latched at start.
  - len == 0: FSM stays in IDLE; the matching done pulse fires the next cycle; no SRAM access.
- LOAD:
  - s_ready = 1 while in LOAD.
  - On each s_valid & s_ready: mem_cs = mem_we = 1, mem_addr = wcnt, mem_wdata = s_data (combinational from the handshake), then wcnt++.
  - When wcnt reaches len-1 and the handshake occurs: go to IDLE next cycle, load_done pulses that cycle, s_ready drops.
  - mem_cs = 0 on cycles with no handshake.
- READ:
  - Issue a read (mem_cs = 1, mem_we = 0, mem_addr = rcnt, rcnt++) when rcnt < len and (buffer occupancy + in-flight reads) < 2.
  - Data is pushed into the buffer the cycle after issue.
  - m_valid = buffer non-empty; m_data = head entry.
  - m_last = 1 when the head is word len-1.
  - Pop on m_valid & m_ready.
  - On the handshake of the last word: rd_done pulses the next cycle and the FSM returns to IDLE.
  - With m_ready held at 1: first m_valid 2 cycles after the rd_start cycle, then one word per cycle, no bubbles.
- Buffer is a 2-entry FIFO. Push and pop in the same cycle are allowed when non-empty.
- busy = (state != IDLE).
- Word order is preserved. Addresses never wrap: len is at most DEPTH.

Test Plan:
- LOAD 16 then READ 16, m_ready = 1:
  - load_start with cfg_len = 16, s_data = 0x0100 + i, s_valid always high -> 16 writes at addr 0..15, load_done at cycle 16.
  - rd_start -> m_data 0x0100..0x010F on consecutive cycles, m_last only on 0x010F, rd_done the next cycle.
- Back-pressure: READ of 8 words with m_ready toggling 1,0,0,1,... -> no lost or duplicated words, order 0..7, never more than 2 reads outstanding, m_data held stable while m_valid & !m_ready.
- DMA gaps: cfg_len = 5, s_valid random with 50% duty -> exactly 5 writes with sequential addresses, no write on idle cycles, load_done after the 5th handshake.
- Length edges:
  - cfg_len = 0 -> done pulse, no mem_cs.
  - cfg_len = 20 -> exactly 16 accesses.
  - rd_start while in LOAD is ignored.
  - Simultaneous load_start and rd_start enter LOAD.
- Reset mid-READ:
  - Assert rst after 3 words -> next cycle all outputs 0, no rd_done.
  - New rd_start, cfg_len = 4 -> returns the previously loaded words 0..3 intact.
